// File: rtl/regbank16x32.sv
// rtl/regbank16x32.sv - 16x32 register bank with per-entry valid flags and sequential clear
//
// Ports:
//   clk        in   1   rising-edge clock
//   rst_n      in   1   synchronous active-low reset
//   we         in   1   write request
//   waddr      in   5   write entry index (0-15 legal, 16-31 rejected)
//   wdata      in  32   write data
//   clr_req    in   1   start a 16-cycle clear sweep (honoured only in IDLE)
//   regs_out   out 512  flattened entries, entry k at [511-32k -: 32]
//   valid_out  out  16  valid flags, entry k at bit 15-k
//   clr_busy   out   1  high while the sweep runs
//   clr_done   out   1  one-cycle pulse after the sweep
//   wr_err     out   1  one-cycle pulse after a rejected write

module regbank16x32 (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         we,
    input  logic [4:0]   waddr,
    input  logic [31:0]  wdata,
    input  logic         clr_req,
    output logic [511:0] regs_out,
    output logic [15:0]  valid_out,
    output logic         clr_busy,
    output logic         clr_done,
    output logic         wr_err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLEAR = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [3:0]  r_ptr;
    logic [3:0]  w_ptr_next;

    logic [31:0] r_regs [16];
    logic [15:0] r_valid;
    logic        r_clr_busy;
    logic        r_clr_done;
    logic        r_wr_err;

    logic        w_addr_ok;
    logic        w_wr_fire;
    logic        w_wr_reject;

    // Entries 16..31 do not exist: the top address bit alone marks them illegal.
    assign w_addr_ok   = ~waddr[4];
    // Writes are only accepted while idle; anything else is dropped and flagged.
    assign w_wr_fire   = we && w_addr_ok && (r_state == S_IDLE);
    assign w_wr_reject = we && (!w_addr_ok || (r_state != S_IDLE));

    always_comb begin
        w_state_next = r_state;
        w_ptr_next   = r_ptr;
        case (r_state)
            S_IDLE: begin
                w_ptr_next = 4'd0;
                if (clr_req) begin
                    w_state_next = S_CLEAR;
                end
            end
            S_CLEAR: begin
                w_ptr_next = r_ptr + 4'd1;
                if (r_ptr == 4'd15) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                w_ptr_next   = 4'd0;
                w_state_next = S_IDLE;
            end
            default: begin
                w_ptr_next   = 4'd0;
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Status flags are registered from the next state so they line up exactly
    // with the state they describe without a combinational decode on the output.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_ptr      <= 4'd0;
            r_clr_busy <= 1'b0;
            r_clr_done <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_ptr      <= w_ptr_next;
            r_clr_busy <= (w_state_next == S_CLEAR);
            r_clr_done <= (w_state_next == S_DONE);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) begin
                r_regs[i] <= 32'd0;
            end
            r_valid  <= 16'd0;
            r_wr_err <= 1'b0;
        end else begin
            r_wr_err <= w_wr_reject;
            if (w_wr_fire) begin
                r_regs[waddr[3:0]]          <= wdata;
                r_valid[4'd15 - waddr[3:0]] <= 1'b1;
            end else if (r_state == S_CLEAR) begin
                r_regs[r_ptr]          <= 32'd0;
                r_valid[4'd15 - r_ptr] <= 1'b0;
            end
        end
    end

    genvar g;
    generate
        for (g = 0; g < 16; g++) begin : g_flat
            assign regs_out[511-32*g -: 32] = r_regs[g];
        end
    endgenerate

    assign valid_out = r_valid;
    assign clr_busy  = r_clr_busy;
    assign clr_done  = r_clr_done;
    assign wr_err    = r_wr_err;

endmodule

// File: tb/tb_regbank16x32.sv
// tb/tb_regbank16x32.sv - self-checking bench for regbank16x32

module tb_regbank16x32;

    logic         clk;
    logic         rst_n;
    logic         we;
    logic [4:0]   waddr;
    logic [31:0]  wdata;
    logic         clr_req;
    logic [511:0] regs_out;
    logic [15:0]  valid_out;
    logic         clr_busy;
    logic         clr_done;
    logic         wr_err;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_mem [16];
    logic [15:0] m_valid;

    regbank16x32 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .we        (we),
        .waddr     (waddr),
        .wdata     (wdata),
        .clr_req   (clr_req),
        .regs_out  (regs_out),
        .valid_out (valid_out),
        .clr_busy  (clr_busy),
        .clr_done  (clr_done),
        .wr_err    (wr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst_n;
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        int          chk_k;
        logic [31:0] exp_data;
        logic [15:0] exp_valid;
        logic        exp_err;
    } vec_t;

    vec_t vecs [11];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] entry(input int k);
        return regs_out[511-32*k -: 32];
    endfunction

    // Expected view at cycle c of a clear sweep (c=0 means idle before it):
    // entry k is swept on the (k+1)-th CLEAR edge, so it reads 0 from cycle k+2.
    task automatic chk_clear_cycle(input int c, input int err_cycle);
        logic [511:0] e;
        logic [15:0]  ev;
        for (int k = 0; k < 16; k++) begin
            e[511-32*k -: 32] = (c >= k + 2) ? 32'd0 : m_mem[k];
            ev[15-k]          = (c >= k + 2) ? 1'b0  : m_valid[15-k];
        end
        chk($sformatf("regs c=%0d", c), regs_out, e);
        chk($sformatf("valid c=%0d", c), {496'd0, valid_out}, {496'd0, ev});
        chk($sformatf("busy c=%0d", c), {511'd0, clr_busy}, {511'd0, (c >= 1 && c <= 16)});
        chk($sformatf("done c=%0d", c), {511'd0, clr_done}, {511'd0, (c == 17)});
        chk($sformatf("wr_err c=%0d", c), {511'd0, wr_err}, {511'd0, (c == err_cycle)});
    endtask

    task automatic fill(input logic [31:0] base);
        for (int k = 0; k < 16; k++) begin
            we    = 1'b1;
            waddr = 5'(k);
            wdata = base + 32'(k);
            step();
            m_mem[k] = base + 32'(k);
        end
        we      = 1'b0;
        m_valid = 16'hFFFF;
    endtask

    task automatic run_clear(input int err_cycle);
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        for (int c = 1; c <= 18; c++) begin
            chk_clear_cycle(c, err_cycle);
            if (c < 18) step();
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        we      = 1'b0;
        waddr   = 5'd0;
        wdata   = 32'd0;
        clr_req = 1'b0;
        step();

        //           rst  we  addr   wdata          k   exp_data       exp_valid  err
        vecs[0]  = '{1'b0, 1'b1, 5'd0,  32'h11111111, 0,  32'h00000000, 16'h0000, 1'b0};
        vecs[1]  = '{1'b1, 1'b1, 5'd0,  32'hDEADBEEF, 0,  32'hDEADBEEF, 16'h8000, 1'b0};
        vecs[2]  = '{1'b1, 1'b1, 5'd15, 32'h12345678, 15, 32'h12345678, 16'h8001, 1'b0};
        vecs[3]  = '{1'b1, 1'b1, 5'd20, 32'hFFFFFFFF, 0,  32'hDEADBEEF, 16'h8001, 1'b1};
        vecs[4]  = '{1'b1, 1'b0, 5'd20, 32'hFFFFFFFF, 15, 32'h12345678, 16'h8001, 1'b0};
        vecs[5]  = '{1'b1, 1'b1, 5'd16, 32'hFFFFFFFF, 0,  32'hDEADBEEF, 16'h8001, 1'b1};
        vecs[6]  = '{1'b1, 1'b1, 5'd31, 32'hFFFFFFFF, 15, 32'h12345678, 16'h8001, 1'b1};
        vecs[7]  = '{1'b1, 1'b1, 5'd5,  32'hAAAA0005, 5,  32'hAAAA0005, 16'h8401, 1'b0};
        vecs[8]  = '{1'b1, 1'b1, 5'd5,  32'hBBBB0005, 5,  32'hBBBB0005, 16'h8401, 1'b0};
        vecs[9]  = '{1'b1, 1'b1, 5'd5,  32'hCCCC0005, 5,  32'hCCCC0005, 16'h8401, 1'b0};
        vecs[10] = '{1'b1, 1'b0, 5'd0,  32'h00000000, 0,  32'hDEADBEEF, 16'h8401, 1'b0};

        for (int i = 0; i < 11; i++) begin
            rst_n = vecs[i].rst_n;
            we    = vecs[i].we;
            waddr = vecs[i].waddr;
            wdata = vecs[i].wdata;
            step();
            chk($sformatf("vec%0d entry%0d", i, vecs[i].chk_k),
                {480'd0, entry(vecs[i].chk_k)}, {480'd0, vecs[i].exp_data});
            chk($sformatf("vec%0d valid", i), {496'd0, valid_out}, {496'd0, vecs[i].exp_valid});
            chk($sformatf("vec%0d wr_err", i), {511'd0, wr_err}, {511'd0, vecs[i].exp_err});
            chk($sformatf("vec%0d busy/done", i), {510'd0, clr_busy, clr_done}, 512'd0);
        end
        we = 1'b0;

        // Full fill then sweep.
        fill(32'hC0DE0000);
        chk_clear_cycle(0, -1);
        run_clear(-1);

        // Write during CLEAR cycle 8 and clr_req during cycle 10 are both ignored.
        fill(32'h40000000);
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        for (int c = 1; c <= 18; c++) begin
            chk_clear_cycle(c, 9);
            if (c < 18) begin
                if (c == 8) begin
                    we    = 1'b1;
                    waddr = 5'd3;
                    wdata = 32'h33333333;
                end
                if (c == 10) clr_req = 1'b1;
                step();
                we      = 1'b0;
                clr_req = 1'b0;
            end
        end

        // Simultaneous write and clr_req in IDLE.
        for (int k = 0; k < 16; k++) m_mem[k] = 32'd0;
        m_mem[7] = 32'hA5A5A5A5;
        m_valid  = 16'h0100;
        we      = 1'b1;
        waddr   = 5'd7;
        wdata   = 32'hA5A5A5A5;
        clr_req = 1'b1;
        step();
        we      = 1'b0;
        clr_req = 1'b0;
        for (int c = 1; c <= 18; c++) begin
            chk_clear_cycle(c, -1);
            if (c < 18) step();
        end

        // Reset in the middle of a sweep, with a write in the reset cycle.
        fill(32'h50000000);
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            chk_clear_cycle(c, -1);
            if (c < 6) step();
        end
        rst_n = 1'b0;
        we    = 1'b1;
        waddr = 5'd2;
        wdata = 32'h77777777;
        step();
        rst_n = 1'b1;
        we    = 1'b0;
        chk("rst regs", regs_out, 512'd0);
        chk("rst valid", {496'd0, valid_out}, 512'd0);
        chk("rst flags", {509'd0, clr_busy, clr_done, wr_err}, 512'd0);
        step();
        chk("post-rst flags", {509'd0, clr_busy, clr_done, wr_err}, 512'd0);
        chk("post-rst valid", {496'd0, valid_out}, 512'd0);
        fill(32'h60000000);
        run_clear(-1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
